// File: rtl/skein_odd_round_inv_if.sv
// Handshake bundle for skein_odd_round_inv: an input stream of post-round states
// and an output stream of recovered pre-round states.
interface skein_odd_round_inv_if;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/skein_odd_round_inv.sv
// Inverse of SkeinOddRound: undoes Threefish-1024 rounds 7, 6, 5, 4 (no subkeys),
// one round per clock, behind a valid/ready handshake on each side.
module skein_odd_round_inv (
  input  logic                  clk,
  input  logic                  rst,
  skein_odd_round_inv_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Round counter holds d-4, so rounds 4..7 map onto the full 2-bit range.
  localparam logic [1:0] CNT_FIRST = 2'd3;
  localparam logic [1:0] CNT_LAST  = 2'd0;

  // Rotation constants, row index = d-4, column index = mix pair j.
  localparam logic [5:0] ROT_TABLE [4][8] = '{
    '{6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30},
    '{6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41},
    '{6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25},
    '{6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20}
  };

  localparam logic [3:0] PERM [16] = '{
    4'd0, 4'd9, 4'd2, 4'd13, 4'd6, 4'd11, 4'd4, 4'd15,
    4'd10, 4'd7, 4'd12, 4'd3, 4'd14, 4'd5, 4'd8, 4'd1
  };

  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] r);
    return (x >> r) | (x << (7'd64 - {1'b0, r}));
  endfunction

  // One inverse round: un-permute the words, then un-mix each pair.
  function automatic logic [1023:0] inv_round(input logic [1023:0] y, input logic [1:0] rnd);
    logic [63:0]   v [16];
    logic [63:0]   odd;
    logic [1023:0] x;
    x = '0;
    for (int i = 0; i < 16; i++) begin
      v[PERM[i]] = y[64*i +: 64];
    end
    for (int j = 0; j < 8; j++) begin
      odd                  = ror64(v[2*j+1] ^ v[2*j], ROT_TABLE[rnd][j]);
      x[128*j + 64 +: 64]  = odd;
      x[128*j +: 64]       = v[2*j] - odd;
    end
    return x;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    cnt_q,   cnt_d;
  logic [1023:0] data_q,  data_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          cnt_d   = CNT_FIRST;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        data_d = inv_round(data_q, cnt_q);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_FIRST;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_FIRST;
      // NOTE: the wide state register is reset on purpose so out_data reads zero straight after reset.
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_skein_odd_round_inv.sv
// Directed and round-trip bench for skein_odd_round_inv; expected results come from
// an independent forward SkeinOddRound model (rounds 4..7 mix then permute).
module tb_skein_odd_round_inv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  skein_odd_round_inv_if bus ();

  skein_odd_round_inv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam int TB_ROT [4][8] = '{
    '{41, 9, 37, 31, 12, 47, 44, 30},
    '{16, 34, 56, 51, 4, 53, 42, 41},
    '{31, 44, 47, 46, 19, 42, 44, 25},
    '{9, 48, 35, 52, 23, 31, 37, 20}
  };
  localparam int TB_PERM [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

  function automatic logic [63:0] rol64(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  // Forward Threefish-1024 round d: mix pairs, then y[i] = v[P[i]].
  function automatic logic [1023:0] fwd_round(input logic [1023:0] x, input int d);
    logic [63:0]   v [16];
    logic [1023:0] y;
    logic [63:0]   a, b;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      a        = x[128*j +: 64];
      b        = x[128*j + 64 +: 64];
      v[2*j]   = a + b;
      v[2*j+1] = rol64(b, TB_ROT[d-4][j]) ^ v[2*j];
    end
    for (int i = 0; i < 16; i++) begin
      y[64*i +: 64] = v[TB_PERM[i]];
    end
    return y;
  endfunction

  function automatic logic [1023:0] skein_odd_round(input logic [1023:0] x);
    logic [1023:0] s;
    s = x;
    for (int d = 4; d <= 7; d++) s = fwd_round(s, d);
    return s;
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int w = 0; w < 16; w++) begin
      if (a[64*w +: 64] !== b[64*w +: 64]) return w;
    end
    return 0;
  endfunction

  // Sends one vector from IDLE with out_ready high; returns edges-to-out_valid and the result.
  task automatic do_txn(input logic [1023:0] din, output int lat, output logic [1023:0] dout);
    lat  = -1;
    dout = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = din;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat  = k;
        dout = bus.out_data;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    n_vec++;
    if (bus.out_data !== 1024'd0) begin
      n_err++; $display("FAIL reset_out_data: word %0d is %h, expected 0",
                        first_diff(bus.out_data, '0), bus.out_data[64*first_diff(bus.out_data, '0) +: 64]);
    end
  endtask

  task automatic test_zero();
    int            lat;
    int            busy;
    logic [1023:0] dout;
    lat  = -1;
    busy = 0;
    dout = '1;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!bus.in_ready) busy++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid && lat < 0) begin
        lat  = k;
        dout = bus.out_data;
      end
      if (!bus.in_ready) busy++;
      else break;
    end
    n_vec++;
    if (lat != 4) begin
      n_err++; $display("FAIL zero_latency: got %0d edges, expected 4", lat);
    end
    n_vec++;
    if (dout !== 1024'd0) begin
      n_err++; $display("FAIL zero_data: word %0d is %h, expected 0",
                        first_diff(dout, '0), dout[64*first_diff(dout, '0) +: 64]);
    end
    n_vec++;
    if (busy != 5) begin
      n_err++; $display("FAIL zero_busy_cycles: in_ready low for %0d cycles, expected 5", busy);
    end
  endtask

  task automatic test_directed();
    logic [1023:0] pats [5];
    logic [1023:0] dout;
    int            lat;
    int            w;
    pats[0] = '1;
    for (int i = 0; i < 16; i++) pats[1][64*i +: 64] = 64'(i) * 64'h0101_0101_0101_0101;
    pats[2] = '0;
    pats[2][1023] = 1'b1;
    pats[3] = {128{8'hA5}};
    pats[4] = rand_vec();
    for (int p = 0; p < 5; p++) begin
      do_txn(skein_odd_round(pats[p]), lat, dout);
      n_vec++;
      if (lat != 4) begin
        n_err++; $display("FAIL directed_%0d_latency: got %0d edges, expected 4", p, lat);
      end
      n_vec++;
      if (dout !== pats[p]) begin
        w = first_diff(dout, pats[p]);
        n_err++; $display("FAIL directed_%0d_data: word %0d is %h, expected %h",
                          p, w, dout[64*w +: 64], pats[p][64*w +: 64]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] a, b, d1, d2;
    int            first_k, second_k, extra, w;
    a = rand_vec();
    b = rand_vec();
    d1 = '0; d2 = '0;
    first_k = -1; second_k = -1; extra = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = skein_odd_round(a);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_data = skein_odd_round(b);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 6) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (first_k < 0) begin
          first_k = k; d1 = bus.out_data;
        end else if (second_k < 0) begin
          second_k = k; d2 = bus.out_data;
        end else begin
          extra++;
        end
      end
    end
    n_vec++;
    if (first_k != 4) begin
      n_err++; $display("FAIL b2b_first_latency: got %0d edges, expected 4", first_k);
    end
    n_vec++;
    if (d1 !== a) begin
      w = first_diff(d1, a);
      n_err++; $display("FAIL b2b_first_data: word %0d is %h, expected %h", w, d1[64*w +: 64], a[64*w +: 64]);
    end
    n_vec++;
    if (second_k != 10) begin
      n_err++; $display("FAIL b2b_second_latency: got %0d edges, expected 10", second_k);
    end
    n_vec++;
    if (d2 !== b) begin
      w = first_diff(d2, b);
      n_err++; $display("FAIL b2b_second_data: word %0d is %h, expected %h", w, d2[64*w +: 64], b[64*w +: 64]);
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL b2b_extra_outputs: got %0d, expected 0", extra);
    end
  endtask

  task automatic test_backpressure();
    logic [1023:0] a;
    int            lat, w, late_valid;
    a   = rand_vec();
    lat = -1;
    bus.in_valid  = 1'b1;
    bus.in_data   = skein_odd_round(a);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_data = skein_odd_round(rand_vec());
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat != 4) begin
      n_err++; $display("FAIL bp_latency: got %0d edges, expected 4", lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold_valid cycle %0d: got %b, expected 1", c, bus.out_valid);
      end
      n_vec++;
      if (bus.out_data !== a) begin
        w = first_diff(bus.out_data, a);
        n_err++; $display("FAIL bp_hold_data cycle %0d: word %0d is %h, expected %h",
                          c, w, bus.out_data[64*w +: 64], a[64*w +: 64]);
      end
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold_in_ready cycle %0d: got %b, expected 0", c, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 and 1",
                        bus.out_valid, bus.in_ready);
    end
    late_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) late_valid++;
    end
    n_vec++;
    if (late_valid != 0) begin
      n_err++; $display("FAIL bp_ignored_input: %0d busy cycles after release, expected 0", late_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    seen = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = skein_odd_round(rand_vec());
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrun_in_ready: got %b, expected 1", bus.in_ready);
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrun_out_valid: got %b, expected 0", bus.out_valid);
    end
    n_vec++;
    if (bus.out_data !== 1024'd0) begin
      n_err++; $display("FAIL midrun_out_data: word %0d is %h, expected 0",
                        first_diff(bus.out_data, '0), bus.out_data[64*first_diff(bus.out_data, '0) +: 64]);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL midrun_no_output: out_valid high %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_rst_priority();
    int seen;
    seen = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = skein_odd_round(rand_vec());
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL rstprio_in_ready: got %b, expected 1", bus.in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL rstprio_no_output: out_valid high %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_round_trip();
    localparam int NUM = 1000;
    logic [1023:0] exp_q [$];
    logic [1023:0] cur, exp_v;
    int            sent, recv, w;
    sent = 0;
    recv = 0;
    cur  = rand_vec();
    bus.in_valid  = 1'b0;
    bus.in_data   = skein_odd_round(cur);
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 40000 && recv < NUM; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        recv++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL roundtrip_spurious: output %0d with nothing outstanding", recv);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.out_data !== exp_v) begin
            w = first_diff(bus.out_data, exp_v);
            n_err++; $display("FAIL roundtrip_data %0d: word %0d is %h, expected %h",
                              recv, w, bus.out_data[64*w +: 64], exp_v[64*w +: 64]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(cur);
        sent++;
        cur = rand_vec();
      end
      @(posedge clk); #1;
      bus.in_valid  = (sent < NUM) && ($urandom_range(0, 9) < 7);
      bus.in_data   = skein_odd_round(cur);
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++;
    if (recv != NUM || exp_q.size() != 0) begin
      n_err++; $display("FAIL roundtrip_count: received %0d with %0d outstanding, expected %0d and 0",
                        recv, exp_q.size(), NUM);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_rst_priority();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/skein_odd_round_inv.md
SKEIN_ODD_ROUND_INV -- requirements
Module: skein_odd_round_inv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 Port in_valid  input  1  in_data is valid this cycle.
REQ-005 Port in_ready  output  1  the block can accept in_data this cycle.
REQ-006 Port in_data  input  1024  state after SkeinOddRound; word i = bits [64i+63:64i], i = 0..15.
REQ-007 Port out_valid  output  1  out_data holds a completed result.
REQ-008 Port out_ready  input  1  the consumer accepts out_data this cycle.
REQ-009 Port out_data  output  1024  recovered pre-round state, using the same word layout as in_data.

Function
REQ-010 The block SHALL compute the exact inverse of SkeinOddRound, i.e. undo Threefish-1024 rounds d = 7, 6, 5, 4 in that order, with no subkey handling.
REQ-011 Each inverse round d SHALL first un-permute: v[P[i]] = y[i] for i = 0..15, with P = 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1.
REQ-012 Each inverse round SHALL then un-mix, for j = 0..7: x[2j+1] = ror64(v[2j+1] XOR v[2j], R[d][j]); x[2j] = v[2j] - x[2j+1], using mod 2^64 arithmetic.
REQ-013 The rotation constants SHALL be:
- R[4] = 41,9,37,31,12,47,44,30
- R[5] = 16,34,56,51,4,53,42,41
- R[6] = 31,44,47,46,19,42,44,25
- R[7] = 9,48,35,52,23,31,37,20
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 In IDLE, in_ready SHALL be 1; on in_valid=1 the block SHALL latch in_data into the state register, set round counter cnt=7, and enter RUN.
REQ-016 In RUN, each cycle SHALL apply inverse round cnt to the state register.
REQ-017 In RUN, when cnt=4 the FSM SHALL enter DONE; otherwise cnt SHALL decrement.
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL equal the state register, held stable while out_ready=0.
REQ-019 In DONE, out_ready=1 SHALL return the FSM to IDLE; there is no same-cycle bypass, so in_ready rises the following cycle.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_data/in_valid SHALL be ignored there.
REQ-021 Latency: capture at edge N SHALL give out_valid=1 after edge N+4.
REQ-022 Throughput SHALL be one result per 6 cycles minimum with out_ready held high.
REQ-023 out_data SHALL be driven from the state register at all times; its value is don't-care when out_valid=0.
REQ-024 cnt SHALL be 2 bits (or equivalent) and SHALL never index rounds outside 4..7.

Reset
REQ-025 When rst=1 at an edge, the block SHALL enter IDLE, with out_valid=0, in_ready=1 after that edge, and cnt=7.
REQ-026 The state register reset value SHALL be 0, so out_data=0 after reset.
REQ-027 Reset in RUN or DONE SHALL discard the in-flight result; no out_valid pulse follows.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-029 Golden: in_data = 1024'hF3ED853E...24B48384 (SkeinOddRound golden output) -> out_data = 1024'hA6D8A0A6...A446FA31 (its golden input), full 1024-bit compare, out_valid 4 cycles after capture.
REQ-030 Zero: in_data = 0 -> out_data = 0; in_ready=0 for exactly the RUN+DONE cycles.
REQ-031 Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready=0, second in_valid ignored.
REQ-032 Reset mid-RUN: assert rst at the 2nd RUN cycle -> out_valid never rises, in_ready=1 next cycle, out_data=0.
REQ-033 Round-trip: 1000 random vectors through SkeinOddRound then this block, with random in_valid/out_ready -> every output equals the original vector, in order, with no drops or duplicates.
